// File: rtl/event_report_pkg.sv
// Shared constants, TX state encoding and the report record for the event reporter.
// frame_byte() maps a captured report plus byte index onto the serial frame layout.
package event_report_pkg;

   localparam logic [7:0]  SYNC_BYTE   = 8'hA5;
   localparam int          FRAME_BYTES = 11;
   localparam logic [15:0] LEN_MAX     = 16'hFFFF;
   localparam logic [15:0] PEAK_MAX    = 16'h7FFF;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_SEND = 2'd1;
   localparam logic [1:0] ST_WAIT = 2'd2;

   typedef struct packed {
      logic [7:0]  seq;
      logic [31:0] start;
      logic [15:0] length;
      logic [15:0] peak;
   } report_t;

   function automatic logic [7:0] frame_byte(input report_t r, input logic [7:0] sync,
                                             input logic [3:0] idx);
      logic [7:0] csum;
      csum = sync ^ r.seq ^ r.start[31:24] ^ r.start[23:16] ^ r.start[15:8] ^ r.start[7:0]
           ^ r.length[15:8] ^ r.length[7:0] ^ r.peak[15:8] ^ r.peak[7:0];
      case (idx)
         4'd0:    return sync;
         4'd1:    return r.seq;
         4'd2:    return r.start[31:24];
         4'd3:    return r.start[23:16];
         4'd4:    return r.start[15:8];
         4'd5:    return r.start[7:0];
         4'd6:    return r.length[15:8];
         4'd7:    return r.length[7:0];
         4'd8:    return r.peak[15:8];
         4'd9:    return r.peak[7:0];
         4'd10:   return csum;
         default: return 8'h00;
      endcase
   endfunction

endpackage

// File: rtl/event_accumulator.sv
// Event edge detection plus start/length/peak tracking; fall pulses for one cycle
// with the finished event's figures already on start/length/peak.
module event_accumulator
   import event_report_pkg::*;
(
   input  logic               clock,
   input  logic               reset,
   input  logic               word_valid,
   input  logic signed [15:0] word,
   input  logic               event_in,
   input  logic [31:0]        count,
   output logic               fall,
   output logic [31:0]        start,
   output logic [15:0]        length,
   output logic [15:0]        peak
);

   logic        prev_event;
   logic        active;
   logic        rise;
   logic [15:0] raw;
   logic [15:0] mag;

   assign raw  = $unsigned(word);
   assign rise = event_in && !prev_event;
   assign fall = active && !event_in;

   always_comb begin
      mag = raw;
      if (raw[15]) mag = (raw == 16'h8000) ? PEAK_MAX : (~raw + 16'd1);
   end

   // prev_event resets high so a line already asserted at reset is not taken as a rise
   always_ff @(posedge clock) begin
      if (reset) begin
         prev_event <= 1'b1;
         active     <= 1'b0;
         start      <= '0;
         length     <= '0;
         peak       <= '0;
      end else begin
         prev_event <= event_in;
         if (rise) begin
            active <= 1'b1;
            start  <= count;
            length <= word_valid ? 16'd1 : 16'd0;
            peak   <= word_valid ? mag : 16'd0;
         end else if (fall) begin
            active <= 1'b0;
         end else if (active && word_valid) begin
            if (length != LEN_MAX) length <= length + 16'd1;
            if (mag > peak)        peak   <= mag;
         end
      end
   end

endmodule

// File: rtl/event_reporter.sv
// Captures finished events into a one-deep report slot and serialises each as a
// checksummed frame to a byte UART; events ending while a report is pending are dropped.
module event_reporter #(
   parameter logic [7:0] SYNC_BYTE   = event_report_pkg::SYNC_BYTE,
   parameter int         FRAME_BYTES = event_report_pkg::FRAME_BYTES
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               word_valid,
   input  logic signed [15:0] word,
   input  logic               event_in,
   input  logic               tx_active,
   input  logic               tx_done,
   output logic               tx_dv,
   output logic [7:0]         tx_byte,
   output logic               busy,
   output logic               overrun
);

   localparam logic [3:0] LAST_INDEX = 4'(FRAME_BYTES - 1);

   logic [31:0]               count;
   logic                      fall;
   logic [31:0]               acc_start;
   logic [15:0]               acc_length;
   logic [15:0]               acc_peak;
   event_report_pkg::report_t slot;
   logic                      pending;
   logic [7:0]                seq;
   logic [1:0]                state;
   logic [3:0]                index;
   logic                      frame_end;

   event_accumulator u_acc (
      .clock      (clock),
      .reset      (reset),
      .word_valid (word_valid),
      .word       (word),
      .event_in   (event_in),
      .count      (count),
      .fall       (fall),
      .start      (acc_start),
      .length     (acc_length),
      .peak       (acc_peak)
   );

   always_ff @(posedge clock) begin
      if (reset)           count <= '0;
      else if (word_valid) count <= count + 32'd1;
   end

   assign frame_end = (state == event_report_pkg::ST_WAIT) && tx_done && (index == LAST_INDEX);

   // The slot is only written while no report is pending, so it is frozen for the whole frame
   always_ff @(posedge clock) begin
      if (reset) begin
         slot    <= '0;
         pending <= 1'b0;
         seq     <= '0;
         overrun <= 1'b0;
      end else begin
         if (fall) begin
            if (!pending) begin
               slot.seq    <= seq;
               slot.start  <= acc_start;
               slot.length <= acc_length;
               slot.peak   <= acc_peak;
               seq         <= seq + 8'd1;
               pending     <= 1'b1;
            end else begin
               overrun <= 1'b1;
            end
         end
         if (frame_end) pending <= 1'b0;
      end
   end

   assign tx_dv = (state == event_report_pkg::ST_SEND) && !tx_active;
   assign busy  = (state != event_report_pkg::ST_IDLE);

   always_ff @(posedge clock) begin
      if (reset) begin
         state   <= event_report_pkg::ST_IDLE;
         index   <= '0;
         tx_byte <= '0;
      end else begin
         case (state)
            event_report_pkg::ST_IDLE: begin
               if (pending) begin
                  state   <= event_report_pkg::ST_SEND;
                  index   <= '0;
                  tx_byte <= event_report_pkg::frame_byte(slot, SYNC_BYTE, 4'd0);
               end
            end
            event_report_pkg::ST_SEND: begin
               if (!tx_active) state <= event_report_pkg::ST_WAIT;
            end
            event_report_pkg::ST_WAIT: begin
               if (tx_done) begin
                  if (index == LAST_INDEX) begin
                     state <= event_report_pkg::ST_IDLE;
                  end else begin
                     state   <= event_report_pkg::ST_SEND;
                     index   <= index + 4'd1;
                     tx_byte <= event_report_pkg::frame_byte(slot, SYNC_BYTE, index + 4'd1);
                  end
               end
            end
            default: state <= event_report_pkg::ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_event_reporter.sv
// Randomised and directed bench for event_reporter with a UART responder and a
// behavioural model of event capture and frame contents.
module tb_event_reporter;

   logic               clock = 1'b0;
   logic               reset, word_valid, event_in, tx_active, tx_done;
   logic signed [15:0] word;
   logic               tx_dv, busy, overrun;
   logic [7:0]         tx_byte;

   event_reporter dut (
      .clock      (clock),
      .reset      (reset),
      .word_valid (word_valid),
      .word       (word),
      .event_in   (event_in),
      .tx_active  (tx_active),
      .tx_done    (tx_done),
      .tx_dv      (tx_dv),
      .tx_byte    (tx_byte),
      .busy       (busy),
      .overrun    (overrun)
   );

   always #5 clock = ~clock;

   int checks = 0;
   int errors = 0;

   // stimulus knobs
   logic               s_rst = 1'b1, s_wv = 1'b0, s_ev = 1'b0, force_active = 1'b0;
   logic signed [15:0] s_w = '0;

   // model state
   logic [31:0] m_cnt = '0;
   bit          m_prev = 1'b1, m_in = 1'b0, m_pend = 1'b0, m_ovr = 1'b0;
   logic [31:0] m_start = '0;
   int          m_len = 0, m_peak = 0, m_seq = 0;
   logic [7:0]  exp_frame [11];
   logic [7:0]  got_frame [11];
   logic [7:0]  last_frame [11];
   int          k = 0, uart_cnt = 0, cyc = 0, cap_cyc = 0, frames = 0, dv_count = 0, stall = 0;
   bit          in_flight = 1'b0, after_reset = 1'b0, checking = 1'b0;
   logic [7:0]  held = '0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic int mag(input logic signed [15:0] w);
      int a;
      a = w;
      if (a < 0) a = -a;
      if (a > 32767) a = 32767;
      return a;
   endfunction

   // one clock: drive at negedge, check settled outputs, advance the model past the posedge
   task automatic step();
      logic [7:0] cs;
      reset = s_rst; word_valid = s_wv; word = s_w; event_in = s_ev;
      tx_done = 1'b0;
      if (uart_cnt > 0) begin
         uart_cnt--;
         if (uart_cnt == 0) tx_done = 1'b1;
      end
      tx_active = (uart_cnt > 0) || force_active;
      #1;
      if (checking) begin
         chk("overrun", overrun, m_ovr);
         if (after_reset) begin
            chk("reset_tx_dv", tx_dv, 0);
            chk("reset_tx_byte", tx_byte, 0);
            chk("reset_busy", busy, 0);
         end
         if (!m_pend) chk("busy_idle", busy, 0);
         if (in_flight) begin
            chk("busy_frame", busy, 1);
            chk("tx_byte_hold", tx_byte, held);
            chk("tx_dv_in_wait", tx_dv, 0);
         end
         if (tx_dv === 1'b1) begin
            chk("tx_dv_while_active", tx_active, 0);
            chk("tx_dv_without_report", m_pend, 1);
            if (m_pend && k < 11) chk($sformatf("frame_byte%0d", k), tx_byte, exp_frame[k]);
            if (k == 0) chk("byte0_latency_ge2", (cyc - cap_cyc) >= 2, 1);
         end
         if (m_pend && !in_flight && tx_dv !== 1'b1 && !tx_active) stall++;
         else stall = 0;
         if (stall > 6) begin
            checks++; errors++;
            $display("FAIL tx_stall: no tx_dv for %0d idle cycles, required within 6", stall);
            stall = 0;
         end
      end

      if (s_rst) begin
         m_cnt = '0; m_prev = 1'b1; m_in = 1'b0; m_pend = 1'b0; m_ovr = 1'b0;
         m_start = '0; m_len = 0; m_peak = 0; m_seq = 0;
         k = 0; uart_cnt = 0; in_flight = 1'b0; stall = 0;
         after_reset = 1'b1; checking = 1'b1;
      end else begin
         after_reset = 1'b0;
         if (s_ev && !m_prev) begin
            m_in = 1'b1; m_start = m_cnt;
            m_len = s_wv ? 1 : 0;
            m_peak = s_wv ? mag(s_w) : 0;
         end else if (!s_ev && m_in) begin
            m_in = 1'b0;
            if (!m_pend) begin
               exp_frame[0] = 8'hA5;         exp_frame[1] = 8'(m_seq);
               exp_frame[2] = m_start[31:24]; exp_frame[3] = m_start[23:16];
               exp_frame[4] = m_start[15:8];  exp_frame[5] = m_start[7:0];
               exp_frame[6] = 8'(m_len >> 8); exp_frame[7] = 8'(m_len);
               exp_frame[8] = 8'(m_peak >> 8); exp_frame[9] = 8'(m_peak);
               cs = 8'h00;
               for (int i = 0; i < 10; i++) cs = cs ^ exp_frame[i];
               exp_frame[10] = cs;
               m_pend = 1'b1; cap_cyc = cyc; m_seq = (m_seq + 1) % 256;
            end else begin
               m_ovr = 1'b1;
            end
         end else if (m_in && s_wv) begin
            if (m_len < 65535) m_len++;
            if (mag(s_w) > m_peak) m_peak = mag(s_w);
         end
         m_prev = s_ev;
         if (s_wv) m_cnt = m_cnt + 32'd1;

         if (tx_done) begin
            in_flight = 1'b0;
            if (k == 11) begin
               m_pend = 1'b0; k = 0; frames++;
               for (int i = 0; i < 11; i++) last_frame[i] = got_frame[i];
            end
         end
         if (tx_dv === 1'b1) begin
            held = tx_byte; in_flight = 1'b1;
            if (k < 11) got_frame[k] = tx_byte;
            k++; dv_count++;
            uart_cnt = $urandom_range(2, 5);
         end
      end
      cyc++;
      @(negedge clock);
   endtask

   task automatic idle(input int n);
      s_ev = 1'b0; s_wv = 1'b0;
      repeat (n) step();
   endtask

   task automatic wait_frame(input string name);
      int target = frames + 1;
      int budget = 600;
      s_ev = 1'b0; s_wv = 1'b0;
      while (frames < target && budget > 0) begin
         step();
         budget--;
      end
      if (frames < target) begin
         checks++; errors++;
         $display("FAIL %s: frame not completed within 600 cycles (frames %0d, required %0d)",
                  name, frames, target);
      end
   endtask

   task automatic short_event(input int n);
      s_ev = 1'b1;
      for (int i = 0; i < n; i++) begin
         s_wv = 1'b1; s_w = 16'($urandom_range(0, 200)) - 16'sd100;
         step();
      end
      s_ev = 1'b0; s_wv = 1'b0;
      step();
   endtask

   logic signed [15:0] ev_words [5] = '{16'sd100, -16'sd300, 16'sd7, -16'sd32768, 16'sd50};
   logic [7:0]         ref_a    [11] = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h0A,
                                         8'h00, 8'h05, 8'h7F, 8'hFF, 8'h2A};

   initial begin
      int base, dv0;
      @(negedge clock);
      s_rst = 1'b1; repeat (3) step();
      s_rst = 1'b0;
      chk("reset_overrun_lit", overrun, 0);

      // counter reaches 10, then a 5-sample event
      s_wv = 1'b1; s_ev = 1'b0; s_w = 16'sd1;
      repeat (10) step();
      s_ev = 1'b1;
      for (int i = 0; i < 5; i++) begin
         s_w = ev_words[i]; s_wv = 1'b1; step();
      end
      wait_frame("frame_a");
      for (int i = 0; i < 11; i++) chk($sformatf("lit_frame_a[%0d]", i), last_frame[i], ref_a[i]);

      // samples coincident with rise and fall: first counted, second not
      idle(3);
      s_ev = 1'b1;
      for (int i = 1; i <= 3; i++) begin
         s_wv = 1'b1; s_w = 16'(i); step();
      end
      s_ev = 1'b0; s_wv = 1'b1; s_w = 16'sd1000; step();
      wait_frame("frame_edges");
      chk("lit_edges_seq", last_frame[1], 8'h01);
      chk("lit_edges_len", {last_frame[6], last_frame[7]}, 16'h0003);
      chk("lit_edges_peak", {last_frame[8], last_frame[9]}, 16'h0003);

      // transmitter busy for 20 cycles before byte 0
      idle(2);
      force_active = 1'b1;
      dv0 = dv_count;
      short_event(4);
      repeat (20) step();
      chk("lit_hold_no_dv", dv_count - dv0, 0);
      force_active = 1'b0;
      wait_frame("frame_hold");
      chk("lit_hold_pulses", dv_count - dv0, 11);

      // reset in the middle of byte 4
      idle(2);
      short_event(3);
      begin
         int budget = 400;
         while (!(k == 5 && in_flight) && budget > 0) begin step(); budget--; end
         if (budget == 0) begin
            checks++; errors++;
            $display("FAIL reach_byte4: byte 4 never sent, got k=%0d", k);
         end
      end
      s_rst = 1'b1; step(); s_rst = 1'b0;
      dv0 = dv_count;
      idle(40);
      chk("lit_reset_no_more_bytes", dv_count - dv0, 0);

      // second event ends mid-frame: dropped, overrun, seq continues
      short_event(3);
      idle(2);
      short_event(2);
      chk("lit_overrun_set", overrun, 1);
      base = frames;
      wait_frame("frame_first_after_reset");
      chk("lit_first_seq", last_frame[1], 8'h00);
      idle(40);
      chk("lit_one_frame_only", frames - base, 1);
      short_event(2);
      wait_frame("frame_next_seq");
      chk("lit_next_seq", last_frame[1], 8'h01);

      // length saturation
      idle(2);
      s_ev = 1'b1; s_wv = 1'b1;
      for (int i = 0; i < 70000; i++) begin
         s_w = 16'($urandom); step();
      end
      wait_frame("frame_long");
      chk("lit_long_len", {last_frame[6], last_frame[7]}, 16'hFFFF);

      // randomised traffic
      for (int i = 0; i < 4000; i++) begin
         s_rst = ($urandom_range(0, 999) == 0);
         if ($urandom_range(0, 99) < (s_ev ? 10 : 6)) s_ev = ~s_ev;
         s_wv = ($urandom_range(0, 2) == 0);
         s_w = ($urandom_range(0, 9) == 0) ? -16'sd32768 : 16'($urandom);
         if ($urandom_range(0, 199) == 0) force_active = ~force_active;
         step();
      end
      s_rst = 1'b0; force_active = 1'b0;
      idle(300);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/event_reporter.md
EVENT_REPORTER -- requirements
Module: event_reporter

Interface
REQ-001 SHALL have parameter SYNC_BYTE, default 8'hA5: first byte of every report frame.
REQ-002 SHALL have parameter FRAME_BYTES, default 11: bytes per report frame, fixed by the frame layout.
REQ-003 SHALL have port clock  input  1  rising-edge system clock.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port word_valid  input  1  one-cycle strobe marking a new assembled 16-bit sample.
REQ-006 SHALL have port word  input  16 signed  sample; valid only with word_valid.
REQ-007 SHALL have port event_in  input  1  registered event-detected level from the detector FSM.
REQ-008 SHALL have port tx_active  input  1  UART transmitter busy.
REQ-009 SHALL have port tx_done  input  1  one-cycle pulse; UART transmitter finished a byte.
REQ-010 SHALL have port tx_dv  output  1  one-cycle request to send tx_byte.
REQ-011 SHALL have port tx_byte  output  8  byte to transmit.
REQ-012 SHALL have port busy  output  1  high whenever the TX state machine is not IDLE.
REQ-013 SHALL have port overrun  output  1  sticky; a completed event was dropped.

Function
REQ-014 SHALL keep a 32-bit sample counter, +1 per word_valid, wrapping 0xFFFFFFFF->0.
REQ-015 SHALL detect the event rising edge (event_in=1, previous sample of event_in=0) and latch start = counter value in that cycle, clear length and peak.
REQ-016 SHALL, while event_in=1, count each word_valid into a 16-bit length, saturating at 0xFFFF.
REQ-017 SHALL track peak = max |word| over the event; |-32768| saturates to 32767.
REQ-018 SHALL include a word_valid coincident with the rising-edge cycle; SHALL exclude a word_valid coincident with the cycle event_in is first seen low.
REQ-019 SHALL, on the falling edge, copy {start, length, peak} into the report slot and set pending, if pending=0.
REQ-020 SHALL, on a falling edge with pending=1, drop the event, set overrun, and leave the slot unchanged.
REQ-021 SHALL keep an 8-bit sequence number, incremented per captured report only (wraps 255->0); dropped events do not increment it.
REQ-022 SHALL send the frame as: SYNC_BYTE, seq, start[31:24..7:0], length[15:8], length[7:0], peak[15:8], peak[7:0], checksum = XOR of bytes 0-9.
REQ-023 SHALL use TX states IDLE, SEND, WAIT: IDLE->SEND when pending; SEND asserts tx_dv for exactly one cycle once tx_active=0, then ->WAIT; WAIT->SEND on tx_done with byte index+1; after tx_done of byte 10, clear pending and ->IDLE.
REQ-024 SHALL never assert tx_dv while tx_active=1; tx_byte SHALL be stable from tx_dv until tx_done.
REQ-025 SHALL assert tx_dv for byte 0 no earlier than two clocks after the falling-edge cycle, given tx_active=0.
REQ-026 SHALL accumulate a new event concurrently with transmission of the previous report.
REQ-027 SHALL report a zero-sample event with length 0, peak 0.

Reset
REQ-028 SHALL, on reset, drive tx_dv=0, tx_byte=0, busy=0, overrun=0; clear counter, seq, pending, accumulators, edge history; force IDLE.
REQ-029 SHALL abandon any in-progress event or frame on reset mid-operation; an event_in already high after reset SHALL not count as a rising edge until it is first seen low.

Structure
REQ-030 SHALL place SYNC_BYTE, FRAME_BYTES and the TX state encoding in shared package event_report_pkg.
REQ-031 SHALL implement edge detection, length and peak tracking in sub-module event_accumulator; frame serialisation stays in event_reporter.

Verification
REQ-032 Event high 5 word_valids (100,-300,7,-32768,50), counter at 10 on rise -> frame A5 00 00 00 00 0A 00 05 7F FF, checksum XOR.
REQ-033 Second event ends while first frame is still sending -> overrun=1, one frame only, next captured event uses seq 01.
REQ-034 word_valid coincident with rise and with fall -> length counts the first, excludes the second.
REQ-035 tx_active held high 20 cycles before byte 0 -> tx_dv waits, one pulse per byte, 11 pulses total.
REQ-036 Reset asserted during byte 4 -> tx_dv=0, busy=0 next cycle, no further bytes, seq restarts at 00.
REQ-037 Event with 70000 samples -> length 0xFFFF.
